ram_burst_reader: RTL
=====================

# ram_burst_reader

Single-clock read-side controller for the team's pseudo-dual-port RAM. On a start command it walks a contiguous address range, drives the RAM read port (ReadEnable/ReadAddress), and absorbs the RAM's one-cycle registered read latency. Words are delivered on a valid/ready stream with full backpressure support and one-word-per-cycle throughput. It sits between the RAM read port and any streaming consumer (UART transmitter, display scanner), with the RAM's ReadClock tied to this block's Clock.

## Interface
- ADDRESS_WIDTH, 16, RAM address width; addresses wrap modulo 2**ADDRESS_WIDTH
- DATA_WIDTH, 8, word width
- Clock  input  1  single clock, rising edge; also drives RAM ReadClock
- Reset  input  1  asynchronous, active-low
- Start_i  input  1  start request, sampled only when Busy_o=0
- StartAddress_i  input  ADDRESS_WIDTH  first word address, captured with Start_i
- Length_i  input  ADDRESS_WIDTH+1  word count, captured with Start_i; 0 to 2**ADDRESS_WIDTH
- RamReadEnable_o  input→RAM  output  1  RAM read enable
- RamReadAddress_o  output  ADDRESS_WIDTH  RAM read address
- RamData_i  input  DATA_WIDTH  RAM registered read data, valid the cycle after RamReadEnable_o
- Data_o  output  DATA_WIDTH  stream data
- Valid_o  output  1  stream valid
- Ready_i  input  1  consumer ready; a transfer occurs on a cycle with Valid_o=1 and Ready_i=1
- Busy_o  output  1  burst in progress
- Done_o  output  1  one-cycle pulse at burst completion

## Operation
- States: IDLE, READ, FLUSH.
  - IDLE: Busy_o=0. Start_i=1 with Length_i≠0 captures the address and length, then moves to READ.
  - IDLE, Start_i=1 with Length_i=0: no reads are issued. Done_o pulses the next cycle and Busy_o stays 0.
  - READ: reads are issued under the credit rule below. After the last read is issued, the state moves to FLUSH.
  - FLUSH: no reads. Waits until the in-flight read has landed and the buffer has drained. The edge that pops the final word returns the state to IDLE and asserts Done_o for that next cycle.
- Start_i is ignored while Busy_o=1.
- Internal 2-entry FIFO holds returned words. An in-flight flag marks a read issued in the previous cycle.
- Credit rule: RamReadEnable_o = (state==READ) && ((fifo_count + inflight) < 2 || pop_this_cycle).
  - This is combinational from registered state.
  - The FIFO can never overflow.
- RamReadAddress_o equals the current address register. It increments by 1 after each issued read and wraps from 2**ADDRESS_WIDTH−1 to 0.
- The remaining-count register decrements per issued read. READ→FLUSH occurs on the edge where the read with remaining==1 is issued.
- Data order on the stream equals address order. No words are dropped or duplicated under any Ready_i pattern.
- Data_o and Valid_o come from the FIFO head. Data_o is held stable while Valid_o=1 and Ready_i=0.
- Simultaneous push and pop with fifo_count==2 cannot occur, because the credit rule prevents it.

## Timing
- Reset values: RamReadEnable_o=0, RamReadAddress_o=0, Data_o=0, Valid_o=0, Busy_o=0, Done_o=0. The FIFO is empty, in-flight is cleared, and state is IDLE.
- Reset asserted mid-burst aborts immediately and asynchronously. RAM data returning after reset release is discarded.
- Start accepted at edge N:
  - Busy_o=1 and the first RamReadEnable_o are in cycle N+1.
  - The word is pushed at edge N+2.
  - Valid_o=1 in cycle N+3, so first-word latency is 3 cycles.
- With Ready_i held at 1: one word per cycle, with a gap-free stream of Length words.
- Done_o is high for exactly one cycle, the cycle after the final transfer. Busy_o falls in that same cycle.
- A new Start_i may be accepted in the Done_o cycle.

## Test plan
- RAM preloaded mem[k]=k&0xFF, StartAddress=0x0010, Length=4, Ready_i=1 → stream 0x10,0x11,0x12,0x13 on consecutive cycles. Valid_o first rises 3 cycles after Start. Done_o pulses once, the cycle after 0x13.
- Same burst with Ready_i toggling 1,0,0,1,0,1… → same 4 words in order. RamReadEnable_o is never high while fifo_count+inflight==2 without a pop. Data_o is stable during stalls.
- ADDRESS_WIDTH=4, StartAddress=0xE, Length=4 → addresses E,F,0,1 are issued and the matching data is streamed.
- Length=0 → no RamReadEnable_o, Valid_o stays 0, Done_o pulses 1 cycle after Start. Length=2**ADDRESS_WIDTH with ADDRESS_WIDTH=4 → 16 words, every address read exactly once.
- Start_i pulsed again mid-burst with different address → ignored, and the original burst completes unchanged.
- Reset dropped while Valid_o=1 and a read is in flight → all outputs 0 immediately. After release, Valid_o stays 0 and a new burst of Length=2 at 0x0020 streams exactly 0x20,0x21.

Source files
------------

// File: rtl/ram_burst_reader.sv
// Burst read controller for the pseudo-dual-port RAM read port.
// Walks an address range and streams words over valid/ready with full backpressure.
module ram_burst_reader #(
   parameter int ADDRESS_WIDTH = 16,
   parameter int DATA_WIDTH    = 8
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     Start_i,
   input  logic [ADDRESS_WIDTH-1:0] StartAddress_i,
   input  logic [ADDRESS_WIDTH:0]   Length_i,
   output logic                     RamReadEnable_o,
   output logic [ADDRESS_WIDTH-1:0] RamReadAddress_o,
   input  logic [DATA_WIDTH-1:0]    RamData_i,
   output logic [DATA_WIDTH-1:0]    Data_o,
   output logic                     Valid_o,
   input  logic                     Ready_i,
   output logic                     Busy_o,
   output logic                     Done_o
);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      FLUSH
   } state_t;

   state_t                   r_state;
   state_t                   w_next;
   logic [ADDRESS_WIDTH-1:0] r_addr;
   logic [ADDRESS_WIDTH:0]   r_remaining;
   logic [DATA_WIDTH-1:0]    r_mem [2];
   logic                     r_wr_ptr;
   logic                     r_rd_ptr;
   logic [1:0]               r_count;
   logic                     r_inflight;
   logic                     r_done;

   logic w_pop;
   logic w_push;
   logic w_issue;
   logic w_start_ok;
   logic w_start_zero;
   logic w_last_pop;
   logic w_done_next;

   assign w_pop        = (r_count != 2'd0) && Ready_i;
   assign w_push       = r_inflight;
   assign w_start_ok   = (r_state == IDLE) && Start_i
                         && (Length_i != '0);
   assign w_start_zero = (r_state == IDLE) && Start_i
                         && (Length_i == '0);

   // Issue only while buffer plus in-flight has room, or a pop frees a slot.
   assign w_issue = (r_state == READ)
                    && (((r_count + {1'b0, r_inflight}) < 2'd2)
                        || w_pop);

   assign w_last_pop = (r_state == FLUSH) && !r_inflight
                       && (r_count == 2'd1) && w_pop;

   always_comb begin
      w_next      = r_state;
      w_done_next = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_start_ok) begin
               w_next = READ;
            end else if (w_start_zero) begin
               w_done_next = 1'b1;
            end
         end
         READ: begin
            if (w_issue
                && (r_remaining == (ADDRESS_WIDTH+1)'(1))) begin
               w_next = FLUSH;
            end
         end
         FLUSH: begin
            if (w_last_pop) begin
               w_next      = IDLE;
               w_done_next = 1'b1;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_state     <= IDLE;
         r_done      <= 1'b0;
         r_addr      <= '0;
         r_remaining <= '0;
         r_inflight  <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_done     <= w_done_next;
         r_inflight <= w_issue;
         if (w_start_ok) begin
            r_addr      <= StartAddress_i;
            r_remaining <= Length_i;
         end else if (w_issue) begin
            r_addr      <= r_addr + ADDRESS_WIDTH'(1);
            r_remaining <= r_remaining - (ADDRESS_WIDTH+1)'(1);
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= RamData_i;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign RamReadEnable_o  = w_issue;
   assign RamReadAddress_o = r_addr;
   assign Data_o           = r_mem[r_rd_ptr];
   assign Valid_o          = (r_count != 2'd0);
   assign Busy_o           = (r_state != IDLE);
   assign Done_o           = r_done;

endmodule
